// File: rtl/irq_encoder_32b.sv
`default_nettype none
//============================================================================
// Module      : irq_encoder_32b
// Description : 32-to-5 sequential priority encoder with valid/ack handshake.
//               Request lines are latched into a sticky pending register.
//               The highest-priority pending line is presented as a 5-bit
//               index. The index stays frozen until the consumer acks it,
//               and the ack clears the served pending bit.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters:
//   PRIORITY_LSB  1 = bit 0 highest priority, 0 = bit 31 highest priority
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   req      in  32  request lines, a 1 sets the matching pending bit
//   ack      in   1  consumer accepts idx (ignored while valid=0)
//   mask     in  32  (IRQ_ENCODER_MASK_EN only) 1 = bit not eligible
//   idx      out  5  index of the presented request (registered)
//   valid    out  1  idx holds a pending request (registered)
//   pending  out 32  sticky pending register (registered)
// Build option:
//   IRQ_ENCODER_MASK_EN  adds the mask input. Masked bits still latch into
//                        pending but are not selected while idle.
//============================================================================
module irq_encoder_32b #(
    parameter int unsigned PRIORITY_LSB = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        ack,
`ifdef IRQ_ENCODER_MASK_EN
    input  logic [31:0] mask,
`endif
    output logic [4:0]  idx,
    output logic        valid,
    output logic [31:0] pending
);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PRESENT = 1'b1;

    logic [0:0]  r_state;
    logic [4:0]  r_idx;
    logic [31:0] r_pending;

    logic [0:0]  w_state_nxt;
    logic [4:0]  w_idx_nxt;
    logic [31:0] w_pending_nxt;
    logic [31:0] w_clr;
    logic [31:0] w_eligible;
    logic [4:0]  w_sel;
    logic        w_any;

`ifdef IRQ_ENCODER_MASK_EN
    assign w_eligible = r_pending & ~mask;
`else
    assign w_eligible = r_pending;
`endif

    assign w_any = |w_eligible;

    // Priority search: the scan runs from lowest to highest priority, so the
    // last hit is the winner.
    generate
        if (PRIORITY_LSB != 0) begin : g_lsb_first
            always_comb begin
                w_sel = '0;
                for (int i = 31; i >= 0; i--) begin
                    if (w_eligible[i]) begin
                        w_sel = 5'(i);
                    end
                end
            end
        end else begin : g_msb_first
            always_comb begin
                w_sel = '0;
                for (int i = 0; i < 32; i++) begin
                    if (w_eligible[i]) begin
                        w_sel = 5'(i);
                    end
                end
            end
        end
    endgenerate

    // Served bit is cleared only by an ack of a presented index.
    always_comb begin
        w_clr = '0;
        if (r_state == c_ST_PRESENT && ack) begin
            w_clr[r_idx] = 1'b1;
        end
    end

    // A request arriving in the ack cycle re-sets the bit (set wins).
    assign w_pending_nxt = (r_pending & ~w_clr) | req;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_sel;
                    w_state_nxt = c_ST_PRESENT;
                end
            end
            c_ST_PRESENT: begin
                // idx stays frozen: no pre-emption while presented.
                if (ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_idx     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign idx     = r_idx;
    assign valid   = (r_state == c_ST_PRESENT);
    assign pending = r_pending;

endmodule
`default_nettype wire
